// File: rtl/write_buffer.sv
// Posted block-write buffer between a data cache and data memory: single-cycle
// write-back into a FIFO, youngest-entry read forwarding, and miss reads that take priority over draining.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        C_READ,
  input  logic        C_WRITE,
  input  logic [5:0]  C_ADDRESS,
  input  logic [31:0] C_WRITEDATA,
  output logic [31:0] C_READDATA,
  output logic        C_BUSYWAIT,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic [5:0]  M_ADDRESS,
  output logic [31:0] M_WRITEDATA,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT,
  output logic        BUF_EMPTY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, MWRITE, MREAD, RDONE} state_t;

  state_t           state;
  logic [5:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             req_held;
  logic [31:0]      rd_reg;
  logic             m_read_q;
  logic             m_write_q;
  logic [5:0]       m_addr_q;
  logic [31:0]      m_wdata_q;

  logic             full;
  logic             push;
  logic             pop;
  logic             mem_done;
  logic             hit_any;
  logic [31:0]      fwd_data;

  // Fullness uses the registered count, so a pop on the same edge never admits a push.
  assign full     = (count == CNT_W'(DEPTH));
  assign push     = C_WRITE && !full;
  assign mem_done = req_held && !M_BUSYWAIT;
  assign pop      = (state == MWRITE) && mem_done;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hit_any  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && addr_q[head + PTR_W'(i)] == C_ADDRESS) begin
        hit_any  = 1'b1;
        fwd_data = data_q[head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    C_READDATA = '0;
    C_BUSYWAIT = 1'b0;
    if (C_READ && hit_any)
      C_READDATA = fwd_data;
    else if (state == RDONE)
      C_READDATA = rd_reg;
    if (!RESET)
      C_BUSYWAIT = 1'b0;
    else if (C_WRITE)
      C_BUSYWAIT = full;
    else if (C_READ)
      C_BUSYWAIT = !hit_any && (state != RDONE);
  end

  // NOTE: the entry array has no reset; count/head/tail alone decide validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail] <= C_ADDRESS;
      data_q[tail] <= C_WRITEDATA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      req_held  <= 1'b0;
      rd_reg    <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          req_held <= 1'b0;
          if (C_READ && !hit_any) begin
            state    <= MREAD;
            m_read_q <= 1'b1;
            m_addr_q <= C_ADDRESS;
          end else if (count != '0) begin
            state     <= MWRITE;
            m_write_q <= 1'b1;
            m_addr_q  <= addr_q[head];
            m_wdata_q <= data_q[head];
          end else if (push) begin
            // Empty buffer: the entry being pushed is the head, so start draining it now.
            state     <= MWRITE;
            m_write_q <= 1'b1;
            m_addr_q  <= C_ADDRESS;
            m_wdata_q <= C_WRITEDATA;
          end
        end
        MWRITE: begin
          req_held <= 1'b1;
          if (mem_done) begin
            state     <= IDLE;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
          end
        end
        MREAD: begin
          req_held <= 1'b1;
          if (mem_done) begin
            state    <= RDONE;
            rd_reg   <= M_READDATA;
            m_read_q <= 1'b0;
            m_addr_q <= '0;
          end
        end
        RDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDRESS   = m_addr_q;
  assign M_WRITEDATA = m_wdata_q;
  assign BUF_EMPTY   = (count == '0) && (state != MWRITE);

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a per-cycle vector table for the basic write,
// forwarding and miss-read flows, plus sequences for full stall, read priority and reset abort.
module tb_write_buffer;

  logic        CLK;
  logic        RESET;
  logic        C_READ;
  logic        C_WRITE;
  logic [5:0]  C_ADDRESS;
  logic [31:0] C_WRITEDATA;
  logic [31:0] C_READDATA;
  logic        C_BUSYWAIT;
  logic        M_READ;
  logic        M_WRITE;
  logic [5:0]  M_ADDRESS;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_BUSYWAIT;
  logic        BUF_EMPTY;

  int checks = 0;
  int errors = 0;

  write_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .C_READ(C_READ), .C_WRITE(C_WRITE), .C_ADDRESS(C_ADDRESS),
    .C_WRITEDATA(C_WRITEDATA), .C_READDATA(C_READDATA), .C_BUSYWAIT(C_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS),
    .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT),
    .BUF_EMPTY(BUF_EMPTY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        mbusy;
    logic [31:0] mrdata;
    logic        busy;
    logic [31:0] rdata;
    logic        mr;
    logic        mw;
    logic [5:0]  maddr;
    logic [31:0] mwdata;
    logic        empty;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    C_READ      = 1'b0;
    C_WRITE     = 1'b0;
    C_ADDRESS   = '0;
    C_WRITEDATA = '0;
    M_READDATA  = '0;
    M_BUSYWAIT  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic push_write(input logic [5:0] a, input logic [31:0] d);
    C_WRITE     = 1'b1;
    C_ADDRESS   = a;
    C_WRITEDATA = d;
    #1;
    check("push_no_stall", C_BUSYWAIT, 32'd0);
    tick();
    C_WRITE = 1'b0;
  endtask

  task automatic wait_mwrite(input logic [5:0] a, input logic [31:0] d);
    int n;
    n = 0;
    #1;
    while (!M_WRITE && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("mwrite_seen", M_WRITE, 32'd1);
    check("mwrite_addr", M_ADDRESS, a);
    check("mwrite_data", M_WRITEDATA, d);
    n = 0;
    while (M_WRITE && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("mwrite_done", M_WRITE, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    int mw_seen;

    //           rd wr addr    wdata          mb mrdata        | busy rdata        mr mw maddr  mwdata        empty
    vecs[0]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[1]  = '{0, 1, 6'h05, 32'hAABBCCDD, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[2]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 1, 6'h05, 32'hAABBCCDD, 0};
    vecs[3]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 1, 6'h05, 32'hAABBCCDD, 0};
    vecs[4]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[5]  = '{0, 1, 6'h03, 32'h11111111, 1, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[6]  = '{0, 1, 6'h03, 32'h22222222, 1, 32'h00000000, 0, 32'h00000000, 0, 1, 6'h03, 32'h11111111, 0};
    vecs[7]  = '{1, 0, 6'h03, 32'h00000000, 1, 32'h00000000, 0, 32'h22222222, 0, 1, 6'h03, 32'h11111111, 0};
    vecs[8]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 1, 6'h03, 32'h11111111, 0};
    vecs[9]  = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 0};
    vecs[10] = '{1, 0, 6'h03, 32'h00000000, 0, 32'h00000000, 0, 32'h22222222, 0, 1, 6'h03, 32'h22222222, 0};
    vecs[11] = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 1, 6'h03, 32'h22222222, 0};
    vecs[12] = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[13] = '{1, 0, 6'h10, 32'h00000000, 1, 32'h00000000, 1, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[14] = '{1, 0, 6'h10, 32'h00000000, 1, 32'h00000000, 1, 32'h00000000, 1, 0, 6'h10, 32'h00000000, 1};
    vecs[15] = '{1, 0, 6'h10, 32'h00000000, 0, 32'hDEADBEEF, 1, 32'h00000000, 1, 0, 6'h10, 32'h00000000, 1};
    vecs[16] = '{1, 0, 6'h10, 32'h00000000, 0, 32'h00000000, 0, 32'hDEADBEEF, 0, 0, 6'h00, 32'h00000000, 1};
    vecs[17] = '{0, 0, 6'h00, 32'h00000000, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 6'h00, 32'h00000000, 1};

    // Reset state
    idle_inputs();
    RESET = 1'b0;
    #3;
    check("rst_busywait", C_BUSYWAIT, 32'd0);
    check("rst_readdata", C_READDATA, 32'd0);
    check("rst_mread", M_READ, 32'd0);
    check("rst_mwrite", M_WRITE, 32'd0);
    check("rst_maddr", M_ADDRESS, 32'd0);
    check("rst_mwdata", M_WRITEDATA, 32'd0);
    check("rst_empty", BUF_EMPTY, 32'd1);
    tick();
    tick();
    RESET = 1'b1;

    // Table: single write/drain, duplicate-address forwarding, miss read
    for (int i = 0; i < 18; i++) begin
      C_READ      = vecs[i].rd;
      C_WRITE     = vecs[i].wr;
      C_ADDRESS   = vecs[i].addr;
      C_WRITEDATA = vecs[i].wdata;
      M_BUSYWAIT  = vecs[i].mbusy;
      M_READDATA  = vecs[i].mrdata;
      #1;
      check($sformatf("v%0d_busywait", i), C_BUSYWAIT, vecs[i].busy);
      check($sformatf("v%0d_readdata", i), C_READDATA, vecs[i].rdata);
      check($sformatf("v%0d_mread", i), M_READ, vecs[i].mr);
      check($sformatf("v%0d_mwrite", i), M_WRITE, vecs[i].mw);
      check($sformatf("v%0d_maddr", i), M_ADDRESS, vecs[i].maddr);
      check($sformatf("v%0d_mwdata", i), M_WRITEDATA, vecs[i].mwdata);
      check($sformatf("v%0d_empty", i), BUF_EMPTY, vecs[i].empty);
      tick();
    end

    // Full buffer: fifth write stalls until the first drain pop, then lands on the next edge
    do_reset();
    M_BUSYWAIT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      C_WRITE     = 1'b1;
      C_ADDRESS   = 6'h31 + 6'(i);
      C_WRITEDATA = 32'h10000001 + 32'(i);
      #1;
      check("fill_no_stall", C_BUSYWAIT, 32'd0);
      tick();
    end
    C_ADDRESS   = 6'h35;
    C_WRITEDATA = 32'h10000005;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_stall", C_BUSYWAIT, 32'd1);
      tick();
    end
    M_BUSYWAIT = 1'b0;
    #1;
    check("stall_on_pop_edge", C_BUSYWAIT, 32'd1);
    check("head_in_flight", M_ADDRESS, 32'h31);
    tick();
    #1;
    check("accept_after_pop", C_BUSYWAIT, 32'd0);
    tick();
    C_WRITE = 1'b0;
    wait_mwrite(6'h32, 32'h10000002);
    wait_mwrite(6'h33, 32'h10000003);
    wait_mwrite(6'h34, 32'h10000004);
    wait_mwrite(6'h35, 32'h10000005);
    #1;
    check("full_drained_empty", BUF_EMPTY, 32'd1);

    // Miss read waits for the in-flight write, then beats the remaining drain
    do_reset();
    M_BUSYWAIT = 1'b1;
    push_write(6'h21, 32'hA1A1A1A1);
    push_write(6'h22, 32'hA2A2A2A2);
    C_READ     = 1'b1;
    C_ADDRESS  = 6'h20;
    M_READDATA = 32'h5A5A5A5A;
    #1;
    check("prio_inflight_addr", M_ADDRESS, 32'h21);
    check("prio_read_stall", C_BUSYWAIT, 32'd1);
    M_BUSYWAIT = 1'b0;
    n   = 0;
    bad = 0;
    while (!M_READ && n < 20) begin
      if (M_WRITE && M_ADDRESS != 6'h21) bad++;
      tick();
      #1;
      n++;
    end
    check("prio_mread_seen", M_READ, 32'd1);
    check("prio_no_early_drain", bad, 32'd0);
    check("prio_mread_addr", M_ADDRESS, 32'h20);
    check("prio_entry_pending", BUF_EMPTY, 32'd0);
    n = 0;
    while (C_BUSYWAIT && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("prio_read_released", C_BUSYWAIT, 32'd0);
    check("prio_read_data", C_READDATA, 32'h5A5A5A5A);
    tick();
    C_READ = 1'b0;
    wait_mwrite(6'h22, 32'hA2A2A2A2);

    // Reset during MWRITE aborts the access and discards the queue
    do_reset();
    M_BUSYWAIT = 1'b1;
    push_write(6'h01, 32'h0000_0101);
    push_write(6'h02, 32'h0000_0202);
    push_write(6'h03, 32'h0000_0303);
    #1;
    check("abort_mwrite_active", M_WRITE, 32'd1);
    #2;
    RESET     = 1'b0;
    C_READ    = 1'b1;
    C_ADDRESS = 6'h3F;
    #1;
    check("abort_mwrite_drop", M_WRITE, 32'd0);
    check("abort_empty", BUF_EMPTY, 32'd1);
    check("abort_busywait", C_BUSYWAIT, 32'd0);
    check("abort_readdata", C_READDATA, 32'd0);
    check("abort_maddr", M_ADDRESS, 32'd0);
    C_READ = 1'b0;
    tick();
    RESET      = 1'b1;
    M_BUSYWAIT = 1'b0;
    mw_seen    = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (M_WRITE) mw_seen++;
      tick();
    end
    check("abort_no_replay", mw_seen, 32'd0);
    check("abort_still_empty", BUF_EMPTY, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered block-write entries (power of two, 2..8).
REQ-002 SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-low reset; clears all state the moment it goes low.
REQ-004 SHALL have port: C_READ  input  1  block read request from data cache.
REQ-005 SHALL have port: C_WRITE  input  1  block write-back request from data cache.
REQ-006 SHALL have port: C_ADDRESS  input  6  block address from data cache.
REQ-007 SHALL have port: C_WRITEDATA  input  32  block write data from data cache.
REQ-008 SHALL have port: C_READDATA  output  32  block read data to data cache.
REQ-009 SHALL have port: C_BUSYWAIT  output  1  stall to data cache; request is held until it is low.
REQ-010 SHALL have port: M_READ  output  1  read request to data memory.
REQ-011 SHALL have port: M_WRITE  output  1  write request to data memory.
REQ-012 SHALL have port: M_ADDRESS  output  6  block address to data memory.
REQ-013 SHALL have port: M_WRITEDATA  output  32  block data to data memory.
REQ-014 SHALL have port: M_READDATA  input  32  block data from data memory.
REQ-015 SHALL have port: M_BUSYWAIT  input  1  data memory busy.
REQ-016 SHALL have port: BUF_EMPTY  output  1  high when no entries are queued and no memory write is in flight.

Function
REQ-017 SHALL hold a FIFO of DEPTH entries {addr[5:0], data[31:0]} with head pointer, tail pointer and count (0..DEPTH); pointers wrap modulo DEPTH.
REQ-018 SHALL accept a write (push at tail) on a rising edge when C_WRITE=1 and count<DEPTH; C_BUSYWAIT SHALL be low combinationally in that cycle (single-cycle write-back).
REQ-019 SHALL hold C_BUSYWAIT high while C_WRITE=1 and count=DEPTH; push occurs on the first edge after count drops below DEPTH, and a pop in the same edge does not free the slot early.
REQ-020 SHALL NOT coalesce writes: a write to an address already queued appends a new entry.
REQ-021 SHALL forward on read hit: when C_READ=1 and C_ADDRESS matches any valid entry, C_READDATA SHALL be the data of the youngest matching entry and C_BUSYWAIT low, combinationally, with no memory access.
REQ-022 SHALL use FSM states IDLE, MWRITE, MREAD, RDONE.
REQ-023 IDLE: if C_READ=1 with no hit -> MREAD (read priority over drain); else if count>0 -> MWRITE with the head entry; else stay.
REQ-024 MWRITE: M_WRITE=1, M_ADDRESS/M_WRITEDATA = head entry; on the first edge where M_BUSYWAIT=0 and the request has been asserted for at least 2 cycles, pop the head and go to IDLE.
REQ-025 MREAD: M_READ=1, M_ADDRESS=C_ADDRESS; C_BUSYWAIT=1; with the same completion rule, capture M_READDATA into a register and go to RDONE.
REQ-026 RDONE: C_READDATA = captured register, C_BUSYWAIT=0 for exactly one cycle; then go to IDLE.
REQ-027 SHALL allow a push in any state, including an MWRITE pop edge; count SHALL update as count+push-pop.
REQ-028 SHALL keep M_READ and M_WRITE mutually exclusive; both SHALL be low in IDLE and RDONE.
REQ-029 C_READDATA SHALL be 0 when neither forwarding nor in RDONE.
REQ-030 BUF_EMPTY SHALL equal (count=0) and (state is not MWRITE).

Reset
REQ-031 SHALL, while RESET=0, force: state IDLE, count/head/tail 0, read register 0, C_BUSYWAIT 0, C_READDATA 0, M_READ 0, M_WRITE 0, M_ADDRESS 0, M_WRITEDATA 0, BUF_EMPTY 1.
REQ-032 SHALL discard queued entries and abort any in-flight memory access on reset; no entry is replayed after reset releases.

Verification
REQ-033 Write addr 0x05 data 0xAABBCCDD into empty buffer -> C_BUSYWAIT low that cycle; M_WRITE rises next cycle with 0x05/0xAABBCCDD; after memory completes, BUF_EMPTY=1.
REQ-034 Hold M_BUSYWAIT high, issue 5 writes with DEPTH=4 -> first 4 accepted with no stall; 5th sees C_BUSYWAIT=1 until the first drain pop, then is accepted on the following edge.
REQ-035 Queue 0x03 data 0x11111111, then 0x03 data 0x22222222, then read 0x03 -> C_READDATA=0x22222222 with C_BUSYWAIT=0 in the same cycle, and no M_READ.
REQ-036 With buffer empty, read 0x10, memory returns 0xDEADBEEF -> M_READ asserted; C_BUSYWAIT high until RDONE; C_READDATA=0xDEADBEEF for one cycle.
REQ-037 With 2 entries queued, read missing address 0x20 -> after any in-flight write completes, MREAD precedes the remaining drain; entries then drain in FIFO order.
REQ-038 Pull RESET low during MWRITE with 3 entries queued -> M_WRITE drops immediately; BUF_EMPTY=1; no further M_WRITE after RESET returns high.
